instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Instruction sequencer directly upstream of the processor datapath: holds a small
//  loadable program RAM and a program counter, and drives the processor's 16-bit iin bus.
//  Presents one instruction, holds it stable until the processor pulses done, then advances.
//  Stops on a HALT word or after executing the last address.
// PARAMETERS
//  DEPTH    32  program RAM words
//  ADDR_W    5  PC/address width; DEPTH == 2**ADDR_W
//  HALT_W   16'hFFFF  instruction word treated as HALT (never issued)
// PORTS
//  clk          in   1       rising-edge clock
//  resetn       in   1       async active-low reset
//  load_en      in   1       write load_data to RAM[load_addr]; honoured only in IDLE/HALT
//  load_addr    in   ADDR_W  RAM write address
//  load_data    in   16      RAM write data
//  run          in   1       start program from address 0; honoured only in IDLE/HALT
//  done         in   1       one-cycle pulse from processor: current instruction retired
//  iin          out  16      instruction to processor; stable while instr_valid=1
//  instr_valid  out  1       iin holds a live instruction awaiting done
//  pc           out  ADDR_W  address of instruction in iin / being fetched
//  busy         out  1       state is FETCH, ISSUE or WAIT_DONE
//  halted       out  1       state is HALT
//  instr_count  out  16      instructions retired since last run; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (async, resetn=0): state=IDLE, pc=0, iin=0, instr_valid=0, halted=0,
//   instr_count=0. RAM contents are not reset.
//  RAM: one sync write port (load_en), one sync read port (addr=pc, data next cycle).
//  FSM, all transitions on rising clk:
//   IDLE:      run=1 -> pc=0, instr_count=0, FETCH. load_en writes in same cycle.
//   FETCH:     RAM read of pc issued -> ISSUE.
//   ISSUE:     rdata==HALT_W -> HALT (iin unchanged, instr_valid stays 0);
//              else iin<=rdata, instr_valid<=1 -> WAIT_DONE.
//   WAIT_DONE: iin, pc held. done=1 -> instr_valid<=0, instr_count+=1 (saturating);
//              pc==DEPTH-1 -> HALT (no wrap); else pc<=pc+1 -> FETCH.
//   HALT:      halted=1, pc holds last address. run=1 -> as IDLE (pc=0, count=0, FETCH).
//  Latency: run to first instr_valid = 3 cycles; done to next instr_valid = 3 cycles.
//  done outside WAIT_DONE is ignored. run while busy is ignored. load_en while busy ignored.
//  load_en and run in same cycle (IDLE/HALT): write committed; first fetch sees new data
//   even at address 0.
//  instr_valid rises only on ISSUE->WAIT_DONE, falls only on the done cycle or reset.
//  Reset mid-operation: immediate return to reset values; RAM preserved, so run restarts
//   the same program.
// TESTING
//  1 Reset: drive resetn=0 mid-WAIT_DONE -> iin=0, instr_valid=0, pc=0, busy=0 immediately.
//  2 Load RAM[0..2]=16'h1234,16'h5678,HALT_W; run; done 2 cycles after each valid ->
//    iin 16'h1234 then 16'h5678, then halted=1, pc=2, instr_count=2.
//  3 Hold done=0 for 20 cycles in WAIT_DONE -> iin, pc, instr_valid constant; stray done
//    pulses in IDLE/FETCH/ISSUE -> no pc/count change.
//  4 Fill all 32 words non-HALT, run, answer every done -> 32 issues, pc stops at 31,
//    halted=1, instr_count=32, no wrap to 0.
//  5 load_en to addr 0 and run asserted while busy -> RAM[0] and pc unchanged;
//    same in HALT with run -> new word issued first.
//  6 Latency: run at cycle t -> instr_valid=1 at t+3; done at cycle u -> next valid at u+3.

Source files
------------

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Instruction sequencer that sits directly upstream of the processor datapath.
//   It holds a small loadable program RAM and a program counter, and drives the
//   processor's 16-bit iin bus. One instruction is presented and held stable
//   until the processor pulses done, then the PC advances. The sequencer stops
//   on a HALT word, which is never issued, or after retiring the last address.
//
// Ports
//   clk          rising-edge clock
//   resetn       asynchronous active-low reset
//   load_en      write load_data to RAM[load_addr]; honoured only in IDLE/HALT
//   load_addr    RAM write address
//   load_data    RAM write data
//   run          start the program at address 0; honoured only in IDLE/HALT
//   done         one-cycle pulse from the processor: current instruction retired
//   iin          instruction to the processor; stable while instr_valid=1
//   instr_valid  iin holds a live instruction that is waiting for done
//   pc           address of the instruction in iin, or of the one being fetched
//   busy         state is FETCH, ISSUE or WAIT_DONE
//   halted       state is HALT
//   instr_count  instructions retired since the last run; saturates at 16'hFFFF
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter int          DEPTH  = 32,
  parameter int          ADDR_W = 5,
  parameter logic [15:0] HALT_W = 16'hFFFF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [15:0]       load_data,
  input  logic              run,
  input  logic              done,
  output logic [15:0]       iin,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic [15:0]       instr_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    WAIT_DONE,
    HALT
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [15:0]       mem [DEPTH];
  logic [15:0]       rdata;
  logic              idle_like;

  // Loads and run requests are accepted only while no program is executing.
  assign idle_like = (state == IDLE) || (state == HALT);
  assign busy      = (state == FETCH) || (state == ISSUE) || (state == WAIT_DONE);
  assign halted    = (state == HALT);

  // NOTE: the RAM has no reset branch; its contents survive resetn so that a
  // later run replays the same program, and a reset on a memory array would
  // prevent it from mapping onto a RAM macro.
  always_ff @(posedge clk) begin
    if (load_en && idle_like) begin
      mem[load_addr] <= load_data;
    end
    // A write and a run in the same cycle commit the write first; FETCH reads
    // one cycle later, so the new word is seen even at address 0.
    if (state == FETCH) begin
      rdata <= mem[pc];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge regardless of order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: state_next is defaulted before the case statement so that every path
  // assigns it and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, HALT: begin
        if (run) state_next = FETCH;
      end
      FETCH: state_next = ISSUE;
      ISSUE: state_next = (rdata == HALT_W) ? HALT : WAIT_DONE;
      WAIT_DONE: begin
        if (done) state_next = (pc == LAST_ADDR) ? HALT : FETCH;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers: PC, instruction bus, valid flag and retire counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc          <= '0;
      iin         <= '0;
      instr_valid <= 1'b0;
      instr_count <= '0;
    end else begin
      case (state)
        IDLE, HALT: begin
          if (run) begin
            pc          <= '0;
            instr_count <= '0;
          end
        end
        ISSUE: begin
          // A HALT word is swallowed: iin keeps the last issued instruction.
          if (rdata != HALT_W) begin
            iin         <= rdata;
            instr_valid <= 1'b1;
          end
        end
        WAIT_DONE: begin
          if (done) begin
            instr_valid <= 1'b0;
            if (instr_count != 16'hFFFF) instr_count <= instr_count + 16'd1;
            // The last address halts with pc left on it rather than wrapping.
            if (pc != LAST_ADDR) pc <= pc + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//   Directed self-checking bench for instr_fetch. Inputs are driven 1 ns after
//   a rising edge and outputs are sampled at the same point, so every sample
//   reflects the state just after the preceding edge.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  logic        clk;
  logic        resetn;
  logic        load_en;
  logic [4:0]  load_addr;
  logic [15:0] load_data;
  logic        run;
  logic        done;
  logic [15:0] iin;
  logic        instr_valid;
  logic [4:0]  pc;
  logic        busy;
  logic        halted;
  logic [15:0] instr_count;

  int checks   = 0;
  int failures = 0;

  instr_fetch #(
    .DEPTH (32),
    .ADDR_W(5),
    .HALT_W(16'hFFFF)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .run        (run),
    .done       (done),
    .iin        (iin),
    .instr_valid(instr_valid),
    .pc         (pc),
    .busy       (busy),
    .halted     (halted),
    .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [4:0] addr, input logic [15:0] data);
    load_en   = 1'b1;
    load_addr = addr;
    load_data = data;
    tick(1);
    load_en   = 1'b0;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    tick(1);
    done = 1'b0;
  endtask

  // Bounded wait for instr_valid, then compare the presented instruction.
  task automatic wait_issue(input string tag, input logic [15:0] exp_iin, input logic [4:0] exp_pc);
    int n;
    n = 0;
    while (!instr_valid && n < 10) begin
      tick(1);
      n++;
    end
    check({tag, "_valid"}, instr_valid, 1);
    check({tag, "_iin"}, iin, exp_iin);
    check({tag, "_pc"}, pc, exp_pc);
  endtask

  initial begin
    bit stable;
    resetn    = 1'b0;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;
    run       = 1'b0;
    done      = 1'b0;

    // Reset values.
    #12;
    check("rst_iin", iin, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_pc", pc, 0);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_count", instr_count, 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // Short program with exact latency checks.
    load(5'd0, 16'h1234);
    load(5'd1, 16'h5678);
    load(5'd2, 16'hFFFF);
    run = 1'b1;
    tick(1);                          // edge t: run sampled -> FETCH
    run = 1'b0;
    check("lat_run_t1_busy", busy, 1);
    check("lat_run_t1_valid", instr_valid, 0);
    tick(1);                          // t+2: ISSUE
    check("lat_run_t2_valid", instr_valid, 0);
    tick(1);                          // t+3: WAIT_DONE
    check("lat_run_t3_valid", instr_valid, 1);
    check("p1_iin0", iin, 16'h1234);
    check("p1_pc0", pc, 0);
    tick(2);
    pulse_done();                     // edge u: done sampled -> FETCH
    check("p1_done_valid", instr_valid, 0);
    check("p1_done_count", instr_count, 1);
    check("p1_done_pc", pc, 1);
    tick(1);
    check("lat_done_u2_valid", instr_valid, 0);
    tick(1);
    check("lat_done_u3_valid", instr_valid, 1);
    check("p1_iin1", iin, 16'h5678);
    tick(2);
    pulse_done();
    tick(2);                          // FETCH -> ISSUE -> HALT on HALT_W
    check("p1_halted", halted, 1);
    check("p1_halt_busy", busy, 0);
    check("p1_halt_pc", pc, 2);
    check("p1_halt_count", instr_count, 2);
    check("p1_halt_valid", instr_valid, 0);
    check("p1_halt_iin", iin, 16'h5678);

    // Stray done while in FETCH/ISSUE, then a long stall in WAIT_DONE.
    run  = 1'b1;
    done = 1'b1;
    tick(1);
    run = 1'b0;
    check("stray_fetch_pc", pc, 0);
    check("stray_fetch_count", instr_count, 0);
    tick(1);
    check("stray_issue_count", instr_count, 0);
    tick(1);
    done = 1'b0;
    check("stray_wait_valid", instr_valid, 1);
    check("stray_wait_count", instr_count, 0);
    check("stray_wait_pc", pc, 0);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (iin !== 16'h1234 || pc !== 5'd0 || instr_valid !== 1'b1) stable = 1'b0;
    end
    check("stall_stable", stable, 1);

    // Asynchronous reset mid-WAIT_DONE, away from any clock edge.
    #3;
    resetn = 1'b0;
    #1;
    check("arst_iin", iin, 0);
    check("arst_valid", instr_valid, 0);
    check("arst_pc", pc, 0);
    check("arst_busy", busy, 0);
    check("arst_count", instr_count, 0);
    tick(1);
    resetn = 1'b1;
    pulse_done();                     // stray done in IDLE
    check("stray_idle_pc", pc, 0);
    check("stray_idle_count", instr_count, 0);
    check("stray_idle_busy", busy, 0);

    // RAM survives reset; writes and run while busy are ignored.
    run = 1'b1;
    tick(1);
    run = 1'b0;
    wait_issue("rerun0", 16'h1234, 5'd0);
    load_en   = 1'b1;
    load_addr = 5'd0;
    load_data = 16'hDEAD;
    run       = 1'b1;
    tick(1);
    load_en = 1'b0;
    run     = 1'b0;
    check("busy_run_pc", pc, 0);
    check("busy_run_iin", iin, 16'h1234);
    check("busy_run_valid", instr_valid, 1);
    pulse_done();
    wait_issue("rerun1", 16'h5678, 5'd1);
    pulse_done();
    tick(3);
    check("rerun_halted", halted, 1);
    run = 1'b1;
    tick(1);
    run = 1'b0;
    wait_issue("ram0_kept", 16'h1234, 5'd0);
    pulse_done();
    wait_issue("ram0_kept1", 16'h5678, 5'd1);
    pulse_done();
    tick(3);
    check("ram0_kept_halted", halted, 1);

    // Load and run in the same cycle from HALT: the new word is issued first.
    load_en   = 1'b1;
    load_addr = 5'd0;
    load_data = 16'hABCD;
    run       = 1'b1;
    tick(1);
    load_en = 1'b0;
    run     = 1'b0;
    wait_issue("ldrun", 16'hABCD, 5'd0);
    pulse_done();
    wait_issue("ldrun1", 16'h5678, 5'd1);
    pulse_done();
    tick(3);
    check("ldrun_halted", halted, 1);

    // Full 32-word program with no HALT word: stops at the last address.
    for (int i = 0; i < 32; i++) load(5'(i), 16'h0100 + 16'(i));
    run = 1'b1;
    tick(1);
    run = 1'b0;
    for (int i = 0; i < 32; i++) begin
      wait_issue($sformatf("full%0d", i), 16'h0100 + 16'(i), 5'(i));
      pulse_done();
    end
    check("full_halted", halted, 1);
    check("full_pc", pc, 31);
    check("full_count", instr_count, 32);
    check("full_valid", instr_valid, 0);
    tick(5);
    check("full_nowrap_pc", pc, 31);
    check("full_nowrap_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
